// File: rtl/ibex_cheri_ccsr_pkg.sv
// Shared types for the CHERI capability-exception CSR (MCCSR).
// Optional drop counter is enabled with IBEX_CHERI_CCSR_DROP_CNT_EN.
package ibex_cheri_ccsr_pkg;

  localparam logic [11:0] CSR_MCCSR  = 12'hBC0;
  localparam logic [5:0]  CAPIDX_PCC = 6'h20;

  typedef enum logic [5:0] {
    EXC_CAUSE_CHERI = 6'h1C
  } exc_cause_e;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ccsr_state_e;

  typedef struct packed {
    logic [7:0] drop_cnt;
    logic [7:0] rsvd_hi;
    logic [5:0] capidx;
    logic [4:0] cause;
    logic [3:0] rsvd_lo;
    logic       e;
  } cheri_ccsr_t;

  function automatic cheri_ccsr_t ccsr_pack(input logic [4:0] cause,
                                            input logic [5:0] capidx,
                                            input logic [7:0] drop_cnt);
    cheri_ccsr_t r;
    r          = '0;
    r.e        = 1'b1;
    r.cause    = cause;
    r.capidx   = capidx;
    r.drop_cnt = drop_cnt;
    return r;
  endfunction

endpackage

// File: rtl/ibex_cheri_ccsr.sv
// MCCSR owner: arbitrates IF/EX capability violations, handshakes with the controller,
// commits cause/capidx on ack. Drop counter enabled with IBEX_CHERI_CCSR_DROP_CNT_EN.
module ibex_cheri_ccsr
  import ibex_cheri_ccsr_pkg::*;
#(
  parameter logic [11:0] CCSR_ADDR  = CSR_MCCSR,
  parameter logic [5:0]  EXC_MCAUSE = EXC_CAUSE_CHERI
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_exc_valid_i,
  input  logic [4:0]  if_exc_cause_i,
  input  logic [5:0]  if_exc_capidx_i,
  input  logic        ex_exc_valid_i,
  input  logic [4:0]  ex_exc_cause_i,
  input  logic [5:0]  ex_exc_capidx_i,
  output logic        exc_req_o,
  output logic [5:0]  exc_mcause_o,
  input  logic        exc_ack_i,
  input  logic        exc_flush_i,
  input  logic        csr_access_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_hit_o,
  output logic [31:0] csr_rdata_o
);

  ccsr_state_e state_q, state_d;
  logic        accept, commit, csr_we;
  logic [4:0]  pend_cause_q, cause_q;
  logic [5:0]  pend_capidx_q, capidx_q;
  logic [7:0]  drop_cnt;
  cheri_ccsr_t mccsr, csr_new;
  logic        unused_new;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    commit       = 1'b0;
    exc_req_o    = 1'b0;
    exc_mcause_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_exc_valid_i || ex_exc_valid_i) begin
          accept  = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        exc_req_o    = 1'b1;
        exc_mcause_o = EXC_MCAUSE;
        if (exc_ack_i) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else if (exc_flush_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // EX holds the older instruction, so it wins arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_cause_q  <= '0;
      pend_capidx_q <= '0;
    end else if (accept) begin
      pend_cause_q  <= ex_exc_valid_i ? ex_exc_cause_i  : if_exc_cause_i;
      pend_capidx_q <= ex_exc_valid_i ? ex_exc_capidx_i : if_exc_capidx_i;
    end
  end

  assign csr_hit_o = csr_access_i && (csr_addr_i == CCSR_ADDR);
  assign csr_we    = csr_hit_o && (csr_op_i != CSR_OP_READ) && !commit;
  assign mccsr     = ccsr_pack(cause_q, capidx_q, drop_cnt);

  always_comb begin
    csr_new = mccsr;
    unique case (csr_op_i)
      CSR_OP_WRITE: csr_new = cheri_ccsr_t'(csr_wdata_i);
      CSR_OP_SET:   csr_new = cheri_ccsr_t'(mccsr | csr_wdata_i);
      CSR_OP_CLEAR: csr_new = cheri_ccsr_t'(mccsr & ~csr_wdata_i);
      default:      csr_new = mccsr;
    endcase
  end

  // Only cause/capidx are writable; the remaining fields are fixed or read-only.
  assign unused_new = ^{csr_new.drop_cnt, csr_new.rsvd_hi, csr_new.rsvd_lo, csr_new.e};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_q  <= '0;
      capidx_q <= '0;
    end else if (commit) begin
      cause_q  <= pend_cause_q;
      capidx_q <= pend_capidx_q;
    end else if (csr_we) begin
      cause_q  <= csr_new.cause;
      capidx_q <= csr_new.capidx;
    end
  end

`ifdef IBEX_CHERI_CCSR_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [1:0] drops;
  logic [8:0] drop_sum;
  logic       drop_clr;

  always_comb begin
    drops = '0;
    if (state_q == ST_IDLE) drops = {1'b0, if_exc_valid_i && ex_exc_valid_i};
    else                    drops = {1'b0, if_exc_valid_i} + {1'b0, ex_exc_valid_i};
  end

  assign drop_sum = {1'b0, drop_cnt_q} + {7'b0, drops};
  assign drop_clr = csr_we && (|csr_wdata_i[31:24]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            drop_cnt_q <= '0;
    else if (drop_clr)    drop_cnt_q <= '0;
    else if (drop_sum[8]) drop_cnt_q <= '1;
    else                  drop_cnt_q <= drop_sum[7:0];
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign csr_rdata_o = csr_hit_o ? 32'(mccsr) : '0;

endmodule

// File: doc/ibex_cheri_ccsr.md
Name: ibex_cheri_ccsr

Overview:
- Consumer end of the CHERI capability-exception encoding: receives violation reports from the fetch-side PCC checker and the ID/EX capability checker.
- Arbitrates between the two sources, holds one pending report, and runs a request/acknowledge handshake with the controller.
- On acknowledge, commits cause and capability index into MCCSR (CSR 12'hBC0), which it also serves on the CSR read/write port.
- Sits beside ibex_cs_registers; it is the only writer of MCCSR.

Parameters:
- CCSR_ADDR, 12'hBC0, CSR address decoded as MCCSR.
- EXC_MCAUSE, 6'h1C, mcause value presented with every request.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous reset, active-high.
- if_exc_valid_i  in  1  fetch-side violation report.
- if_exc_cause_i  in  5  cheri_capability_exception_e.
- if_exc_capidx_i  in  6  {scr_flag, reg/scr index}; PCC is 6'h20.
- ex_exc_valid_i  in  1  ID/EX violation report.
- ex_exc_cause_i  in  5  cheri_capability_exception_e.
- ex_exc_capidx_i  in  6  faulting capability index.
- exc_req_o  out  1  CHERI exception pending to controller.
- exc_mcause_o  out  6  EXC_MCAUSE while exc_req_o, else 0.
- exc_ack_i  in  1  controller taking the trap.
- exc_flush_i  in  1  controller discards the pending report.
- csr_access_i  in  1  CSR instruction in EX.
- csr_addr_i  in  12  CSR address.
- csr_op_i  in  2  csr_op_e.
- csr_wdata_i  in  32  CSR operand.
- csr_hit_o  out  1  csr_access_i and csr_addr_i==CCSR_ADDR.
- csr_rdata_o  out  32  MCCSR value, combinational; 0 when not hit.

Behaviour:
- MCCSR layout:
  - [0] E, read-only 1.
  - [4:1] zero.
  - [9:5] cause.
  - [15:10] capidx.
  - [23:16] zero.
  - [31:24] drop count (optional feature), else 0.
- Reset values:
  - MCCSR = 32'h0000_0001.
  - FSM = IDLE.
  - exc_req_o = 0, exc_mcause_o = 0.
  - Pending cause/capidx registers = 0.
- FSM IDLE:
  - Any report valid: latch the winner, go to PEND.
  - Arbitration: EX beats IF when both are valid (EX holds the older instruction); the IF report is dropped.
- FSM PEND:
  - exc_req_o = 1.
  - exc_ack_i: commit pending cause/capidx to MCCSR and go to IDLE.
  - exc_flush_i without ack: go to IDLE with no commit.
  - Ack and flush in the same cycle: ack wins.
  - Reports arriving in PEND (including the ack cycle) are dropped; the pending report is never overwritten.
- Latency:
  - Report in cycle N gives exc_req_o=1 in N+1.
  - Ack in cycle M gives MCCSR updated and exc_req_o=0 in M+1.
  - A new report can be accepted in M+1.
- CSR write:
  - Applies when csr_hit_o and csr_op_i != CSR_OP_READ.
  - new = WRITE: wdata; SET: old|wdata; CLEAR: old&~wdata.
  - Masked to cause/capidx; E stays 1, reserved bits stay 0, drop count is read-only.
  - CSR write and ack commit in the same cycle: the commit wins entirely.
- Reset mid-PEND: returns to IDLE, the pending report is lost, and MCCSR is reinitialised.

Optional Feature:
- Macro: IBEX_CHERI_CCSR_DROP_CNT_EN.
- Defined:
  - 8-bit saturating counter at MCCSR[31:24].
  - +1 per dropped report (both arbitration losses and PEND arrivals; two drops in one cycle add 2).
  - Saturates at 8'hFF.
  - Cleared by a CSR write, set or clear that touches any bit of [31:24] with a 1 in wdata.
  - Reset value 0.
- Undefined: [31:24] reads 0 and the counter logic is absent.

Decomposition:
- Additions to ibex_defines:
  - EXC_CAUSE_CHERI = 6'h1C in exc_cause_e.
  - CSR_MCCSR, already present.
  - cheri_ccsr_t packed struct {drop_cnt[7:0], rsvd[7:0], capidx[5:0], cause[4:0], rsvd[3:0], e}.
  - CAPIDX_PCC = 6'h20.
- No sub-module; the FSM, arbitration and CSR mux fit in one module.

Test Plan:
- Single report: ex_exc_valid_i=1, cause=TAG_VIOLATION(1), capidx=3 at N.
  - exc_req_o=1 and exc_mcause_o=6'h1C at N+1.
  - Ack at N+3: MCCSR=32'h0000_0C21 at N+4.
- Simultaneous sources: IF cause 9 / capidx 6'h20 together with EX cause 16 / capidx 5.
  - Committed MCCSR=32'h0000_1601.
  - Drop count=1 when the macro is defined.
- Report during PEND: second report with cause 2 while pending cause 1.
  - Committed cause stays 1.
  - Drop count increments.
  - Repeating the drop 300 times saturates the count at 8'hFF.
- Flush in PEND: exc_flush_i=1 gives IDLE next cycle and MCCSR unchanged.
  - Ack+flush in the same cycle commits.
- CSR ops on CCSR_ADDR:
  - WRITE 32'hFFFF_FFFF gives 32'h0000_FFE1; CLEAR 32'h0000_0020 gives 32'h0000_FFC1.
  - Other address: csr_hit_o=0, rdata 0.
  - Write in the ack cycle: commit value wins.
- Reset mid-PEND: assert rst_i asynchronously.
  - exc_req_o=0 immediately and MCCSR=32'h1.
  - A report after release is handled normally.
